// File: rtl/ripple_count_sampler_if.sv
// ----------------------------------------------------------------------------
// ripple_count_sampler_if
// Snapshot readout bundle of the ripple count sampler.
//   snap_req    requester -> sampler  capture request (level, sampled per edge)
//   snap_valid  sampler -> consumer   a captured snapshot is being held
//   snap_ready  consumer -> sampler   consumer accepts the held snapshot
//   snap_data   sampler -> consumer   captured extended count
// Modports:
//   master  sampler side (drives snap_valid/snap_data)
//   slave   requester/consumer side (drives snap_req/snap_ready)
// ----------------------------------------------------------------------------
interface ripple_count_sampler_if #(
  parameter int EXT_W = 16
) ();
  logic             snap_req;
  logic             snap_valid;
  logic             snap_ready;
  logic [EXT_W-1:0] snap_data;

  modport master (
    input  snap_req,
    input  snap_ready,
    output snap_valid,
    output snap_data
  );

  modport slave (
    output snap_req,
    output snap_ready,
    input  snap_valid,
    input  snap_data
  );
endinterface

// File: rtl/ripple_count_sampler.sv
// ----------------------------------------------------------------------------
// ripple_count_sampler
// Consumes the value of a free-running asynchronous ripple counter: brings it
// into the clk domain through a two-flop synchronizer, rejects transient codes
// that do not stay put for STABLE_N consecutive edges, and accumulates the
// wrap-aware step count into a wide extended counter. Also provides a
// threshold crossing pulse and a valid/ready snapshot readout.
//
// Optional feature macro: RIPPLE_SAMPLER_GLITCH_CNT_EN
//   defined   -> glitch_cnt_o present: saturating count of rejected codes
//   undefined -> port and logic absent
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high
//   cnt_in_i      ripple counter value, asynchronous to clk
//   clr_i         synchronous clear of ext_count_o and overflow_o
//   thresh_i      threshold for thresh_hit_o
//   ext_count_o   extended accumulated count
//   overflow_o    sticky: ext_count_o wrapped past 2^EXT_W-1
//   thresh_hit_o  one-cycle pulse when ext_count_o crosses thresh_i upward
//   glitch_cnt_o  rejected code count (feature macro only)
//   snap          snapshot readout (master side)
// ----------------------------------------------------------------------------
module ripple_count_sampler #(
  parameter int IN_W     = 4,
  parameter int EXT_W    = 16,
  parameter int STABLE_N = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  cnt_in_i,
  input  logic             clr_i,
  input  logic [EXT_W-1:0] thresh_i,
  output logic [EXT_W-1:0] ext_count_o,
  output logic             overflow_o,
  output logic             thresh_hit_o,
`ifdef RIPPLE_SAMPLER_GLITCH_CNT_EN
  output logic [7:0]       glitch_cnt_o,
`endif
  ripple_count_sampler_if.master snap
);

  localparam int              STAB_W   = $clog2(STABLE_N + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_N);

  logic [IN_W-1:0]   s1_q, s2_q;
  logic [IN_W-1:0]   acc_q, acc_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [EXT_W-1:0]  ext_q, ext_d;
  logic              ovf_q, ovf_d;
  logic              hit_q, hit_d;
  logic              snap_valid_q, snap_valid_d;
  logic [EXT_W-1:0]  snap_data_q, snap_data_d;

  logic              s2_changed;
  logic              update;
  logic [IN_W-1:0]   delta;
  logic [EXT_W:0]    sum;

  always_comb begin
    s2_changed = (s1_q != s2_q);

    // stab counts edges on which s2 has held its current value
    if (s2_changed) begin
      stab_d = STAB_W'(1);
    end else if (stab_q == STAB_MAX) begin
      stab_d = stab_q;
    end else begin
      stab_d = stab_q + STAB_W'(1);
    end

    // Accept on the edge where stability is reached; s1_q equals s2_q then,
    // so s1_q is the value s2 holds after this edge.
    update = (stab_d == STAB_MAX) && (s1_q != acc_q);
    delta  = s1_q - acc_q;                     // modulo 2^IN_W, handles wrap
    sum    = {1'b0, ext_q} + (EXT_W + 1)'(delta);

    acc_d = update ? s1_q : acc_q;
    ext_d = ext_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      // clear still keeps the events accepted on this same edge
      ext_d = update ? EXT_W'(delta) : '0;
      ovf_d = 1'b0;
    end else if (update) begin
      ext_d = sum[EXT_W-1:0];
      ovf_d = ovf_q | sum[EXT_W];
    end

    hit_d = !clr_i && (ext_q < thresh_i) && (ext_d >= thresh_i);

    // snapshot takes the pre-update count; requests while holding are ignored
    snap_valid_d = snap_valid_q;
    snap_data_d  = snap_data_q;
    if (!snap_valid_q) begin
      if (snap.snap_req) begin
        snap_valid_d = 1'b1;
        snap_data_d  = ext_q;
      end
    end else if (snap.snap_ready) begin
      snap_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q         <= '0;
      s2_q         <= '0;
      acc_q        <= '0;
      stab_q       <= '0;
      ext_q        <= '0;
      ovf_q        <= 1'b0;
      hit_q        <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_data_q  <= '0;
    end else begin
      s1_q         <= cnt_in_i;
      s2_q         <= s1_q;
      acc_q        <= acc_d;
      stab_q       <= stab_d;
      ext_q        <= ext_d;
      ovf_q        <= ovf_d;
      hit_q        <= hit_d;
      snap_valid_q <= snap_valid_d;
      snap_data_q  <= snap_data_d;
    end
  end

`ifdef RIPPLE_SAMPLER_GLITCH_CNT_EN
  logic [7:0] glitch_q, glitch_d;

  // a code that s2 abandons before it became stable was never accepted
  always_comb begin
    glitch_d = glitch_q;
    if (clr_i) begin
      glitch_d = '0;
    end else if (s2_changed && (stab_q < STAB_MAX) && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_cnt_o = glitch_q;
`endif

  assign ext_count_o     = ext_q;
  assign overflow_o      = ovf_q;
  assign thresh_hit_o    = hit_q;
  assign snap.snap_valid = snap_valid_q;
  assign snap.snap_data  = snap_data_q;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// ----------------------------------------------------------------------------
// tb_ripple_count_sampler
// Bench for ripple_count_sampler. Instance A uses default parameters; instance
// B uses EXT_W=6 for the wrap/overflow scenario. Extended-count updates of A
// are predicted when the ripple value is driven and matched (value and edge)
// when A's output changes.
// ----------------------------------------------------------------------------
module tb_ripple_count_sampler;

  typedef struct {
    logic [15:0] val;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [3:0]  cnt_a, cnt_b;
  logic        clr_a, clr_b;
  logic [15:0] thresh_a;
  logic [5:0]  thresh_b;
  logic [15:0] ext_a;
  logic [5:0]  ext_b;
  logic        ovf_a, ovf_b;
  logic        hit_a, hit_b;
`ifdef RIPPLE_SAMPLER_GLITCH_CNT_EN
  logic [7:0]  glitch_a, glitch_b;
`endif

  ripple_count_sampler_if #(.EXT_W(16)) snap_a ();
  ripple_count_sampler_if #(.EXT_W(6))  snap_b ();

  ripple_count_sampler #(.IN_W(4), .EXT_W(16), .STABLE_N(2)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .cnt_in_i     (cnt_a),
    .clr_i        (clr_a),
    .thresh_i     (thresh_a),
    .ext_count_o  (ext_a),
    .overflow_o   (ovf_a),
    .thresh_hit_o (hit_a),
`ifdef RIPPLE_SAMPLER_GLITCH_CNT_EN
    .glitch_cnt_o (glitch_a),
`endif
    .snap         (snap_a.master)
  );

  ripple_count_sampler #(.IN_W(4), .EXT_W(6), .STABLE_N(2)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .cnt_in_i     (cnt_b),
    .clr_i        (clr_b),
    .thresh_i     (thresh_b),
    .ext_count_o  (ext_b),
    .overflow_o   (ovf_b),
    .thresh_hit_o (hit_b),
`ifdef RIPPLE_SAMPLER_GLITCH_CNT_EN
    .glitch_cnt_o (glitch_b),
`endif
    .snap         (snap_b.master)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  exp_t        exp_q[$];
  exp_t        e_mon;
  logic        mon_en   = 1'b0;
  logic [15:0] last_ext = '0;
  logic [15:0] model_ext = '0;
  logic [3:0]  model_acc = '0;
  int          hit_cnt_a = 0;
  int          hit_cnt_b = 0;
  logic [15:0] hit_ext   = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard side: every change of A's count must match the oldest prediction
  always @(negedge clk) begin
    if (!reset && mon_en && (ext_a !== last_ext)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL ext_count_change: got %0d at edge %0d, required no change from %0d",
                 ext_a, cyc, last_ext);
      end else begin
        e_mon = exp_q.pop_front();
        if (ext_a !== e_mon.val || cyc != e_mon.cyc) begin
          n_fail++;
          $display("FAIL ext_count_update: got %0d at edge %0d, required %0d at edge %0d",
                   ext_a, cyc, e_mon.val, e_mon.cyc);
        end else begin
          $display("update ext_count=%0d at edge %0d", ext_a, cyc);
        end
      end
    end
    last_ext = ext_a;
    if (!reset && hit_a) begin
      hit_cnt_a++;
      hit_ext = ext_a;
    end
    if (!reset && hit_b) hit_cnt_b++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive a ripple value on A (called just after a rising edge), predict the
  // resulting update, then hold it for n edges.
  task automatic hold(input logic [3:0] v, input int n);
    logic [3:0] d;
    exp_t       e;
    d     = v - model_acc;
    cnt_a = v;
    if (d != 4'd0) begin
      model_acc = v;
      model_ext = model_ext + 16'(d);
      e.val = model_ext;
      e.cyc = cyc + 3;
      exp_q.push_back(e);
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d pending updates, required 0", name, exp_q.size());
    end
  endtask

  // Clear A's count with no update on the same edge; monitor paused meanwhile.
  task automatic clear_a();
    mon_en = 1'b0;
    clr_a  = 1'b1;
    @(posedge clk); #1;
    clr_a  = 1'b0;
    model_ext = '0;
    n_checks++;
    if (ext_a !== 16'd0 || ovf_a !== 1'b0) begin
      n_fail++;
      $display("FAIL clear: got ext=%0d ovf=%0b, required ext=0 ovf=0", ext_a, ovf_a);
    end
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cnt_a = 4'd9;
    cnt_b = 4'd0;
    clr_a = 1'b0;
    clr_b = 1'b0;
    thresh_a = '0;
    thresh_b = '0;
    snap_a.snap_req = 1'b0;
    snap_a.snap_ready = 1'b0;
    snap_b.snap_req = 1'b0;
    snap_b.snap_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (ext_a !== 16'd0 || ovf_a !== 1'b0 || hit_a !== 1'b0 ||
        snap_a.snap_valid !== 1'b0 || snap_a.snap_data !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ext=%0d ovf=%0b hit=%0b sv=%0b sd=%0d, required all 0",
               ext_a, ovf_a, hit_a, snap_a.snap_valid, snap_a.snap_data);
    end
`ifdef RIPPLE_SAMPLER_GLITCH_CNT_EN
    n_checks++;
    if (glitch_a !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_glitch: got %0d, required 0", glitch_a);
    end
`endif
    cnt_a = 4'd0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    last_ext = ext_a;
    mon_en = 1'b1;
    hold(4'd0, 10);
    n_checks++;
    if (ext_a !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_release_hold: got %0d, required 0", ext_a);
    end
    $display("reset done ext_count=%0d", ext_a);
  endtask

  task automatic test_count();
    for (int i = 0; i < 21; i++) hold(4'(i % 16), 8);
    check_drained("count");
    n_checks++;
    if (ext_a !== model_ext || ovf_a !== 1'b0) begin
      n_fail++;
      $display("FAIL count_final: got ext=%0d ovf=%0b, required ext=%0d ovf=0",
               ext_a, ovf_a, model_ext);
    end
    $display("count done ext_count=%0d", ext_a);
  endtask

  task automatic test_glitch();
    hold(4'd5, 8);
    cnt_a = 4'd7;                 // present for a single cycle only
    @(posedge clk); #1;
    hold(4'd6, 10);
    check_drained("glitch");
`ifdef RIPPLE_SAMPLER_GLITCH_CNT_EN
    n_checks++;
    if (glitch_a !== 8'd1) begin
      n_fail++;
      $display("FAIL glitch_cnt: got %0d, required 1", glitch_a);
    end
`endif
    $display("glitch done ext_count=%0d", ext_a);
  endtask

  task automatic test_thresh();
    thresh_a = 16'd10;
    clear_a();
    hit_cnt_a = 0;
    for (int i = 0; i < 12; i++) hold(model_acc + 4'd1, 6);
    check_drained("thresh");
    n_checks++;
    if (hit_cnt_a != 1 || hit_ext !== 16'd10) begin
      n_fail++;
      $display("FAIL thresh_hit: got %0d pulse cycles at ext=%0d, required 1 at ext=10",
               hit_cnt_a, hit_ext);
    end
    thresh_a = '0;
    $display("thresh done pulses=%0d", hit_cnt_a);
  endtask

  task automatic test_snapshot();
    clear_a();
    for (int i = 0; i < 3; i++) hold(model_acc + 4'd1, 8);
    snap_a.snap_req = 1'b1;
    @(posedge clk); #1;
    snap_a.snap_req = 1'b0;
    n_checks++;
    if (snap_a.snap_valid !== 1'b1 || snap_a.snap_data !== 16'd3) begin
      n_fail++;
      $display("FAIL snap_capture: got valid=%0b data=%0d, required valid=1 data=3",
               snap_a.snap_valid, snap_a.snap_data);
    end
    for (int i = 0; i < 2; i++) hold(model_acc + 4'd1, 8);
    snap_a.snap_req = 1'b1;
    @(posedge clk); #1;
    snap_a.snap_req = 1'b0;
    n_checks++;
    if (snap_a.snap_valid !== 1'b1 || snap_a.snap_data !== 16'd3) begin
      n_fail++;
      $display("FAIL snap_hold: got valid=%0b data=%0d, required valid=1 data=3",
               snap_a.snap_valid, snap_a.snap_data);
    end
    // handshake with a simultaneous request: request must be ignored
    snap_a.snap_ready = 1'b1;
    snap_a.snap_req   = 1'b1;
    @(posedge clk); #1;
    snap_a.snap_req = 1'b0;
    n_checks++;
    if (snap_a.snap_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL snap_release: got valid=%0b, required 0", snap_a.snap_valid);
    end
    @(posedge clk); #1;
    snap_a.snap_ready = 1'b0;
    n_checks++;
    if (snap_a.snap_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL snap_idle_ready: got valid=%0b, required 0", snap_a.snap_valid);
    end
    check_drained("snapshot");
    $display("snapshot done data=%0d", snap_a.snap_data);
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 64; i++) begin
      cnt_b = 4'(i);
      repeat (5) @(posedge clk);
      #1;
      if (i == 63) begin
        n_checks++;
        if (ext_b !== 6'd63 || ovf_b !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_before_wrap: got ext=%0d ovf=%0b, required ext=63 ovf=0",
                   ext_b, ovf_b);
        end
      end
    end
    n_checks++;
    if (ext_b !== 6'd0 || ovf_b !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_wrap: got ext=%0d ovf=%0b, required ext=0 ovf=1", ext_b, ovf_b);
    end
    // +1 step accepted on the same edge as the clear
    cnt_b = 4'd1;
    repeat (2) @(posedge clk);
    #1;
    clr_b = 1'b1;
    @(posedge clk); #1;
    clr_b = 1'b0;
    n_checks++;
    if (ext_b !== 6'd1 || ovf_b !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_with_update: got ext=%0d ovf=%0b, required ext=1 ovf=0", ext_b, ovf_b);
    end
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (ext_b !== 6'd1 || hit_cnt_b != 0) begin
      n_fail++;
      $display("FAIL clr_settle: got ext=%0d pulses=%0d, required ext=1 pulses=0",
               ext_b, hit_cnt_b);
    end
    $display("overflow done ext_count=%0d", ext_b);
  endtask

  initial begin
    test_reset();
    test_count();
    test_glitch();
    test_thresh();
    test_snapshot();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
